// File: rtl/instruction_buffer.sv
// Circular decoupling queue between 4-wide fetch/decode and dispatch.
// Optional sticky overflow/underflow flag enabled by defining IBUF_ERR_CHECK_EN.
module instruction_buffer #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 41
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic [2:0]                  in_count,
   input  logic [4*ENTRY_W-1:0]        in_entry_flat,
   output logic [2:0]                  num_free,
   output logic [4*ENTRY_W-1:0]        out_entry_flat,
   output logic [3:0]                  out_valid,
   input  logic [2:0]                  deq_count,
   output logic [$clog2(DEPTH):0]      occupancy,
   output logic                        err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] in_lane [4];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] occ_q, occ_d;

   logic [2:0] in_clamp;
   logic [2:0] deq_clamp;
   logic [2:0] free_cnt;
   logic [2:0] avail_cnt;
   logic [2:0] enq_cnt;
   logic [2:0] deq_cnt;

   // Input lane 0 sits in the most significant slice of the flat bus.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         in_lane[j] = in_entry_flat[(3-j)*ENTRY_W +: ENTRY_W];
      end
   end

   // Free slots depend only on registered occupancy, keeping fetch loop-free.
   always_comb begin
      free_cnt = 3'd4;
      if (occ_q >= CNT_W'(DEPTH - 4)) begin
         free_cnt = 3'(DEPTH - int'(occ_q));
      end
   end

   always_comb begin
      avail_cnt = 3'd4;
      if (occ_q < CNT_W'(4)) begin
         avail_cnt = 3'(occ_q);
      end
   end

   always_comb begin
      in_clamp  = (in_count  > 3'd4) ? 3'd4 : in_count;
      deq_clamp = (deq_count > 3'd4) ? 3'd4 : deq_count;
      enq_cnt   = (in_clamp  > free_cnt)  ? free_cnt  : in_clamp;
      deq_cnt   = (deq_clamp > avail_cnt) ? avail_cnt : deq_clamp;
   end

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         head_d = head_q + PTR_W'(deq_cnt);
         tail_d = tail_q + PTR_W'(enq_cnt);
         occ_d  = occ_q + CNT_W'(enq_cnt) - CNT_W'(deq_cnt);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   // Storage has no reset; each slot picks whichever accepted lane maps onto it.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic             wr_en;
         logic [ENTRY_W-1:0] wr_data;

         always_comb begin
            wr_en   = 1'b0;
            wr_data = mem_q[gi];
            for (int j = 0; j < 4; j++) begin
               if (!flush && (3'(j) < enq_cnt) &&
                   ((tail_q + PTR_W'(j)) == PTR_W'(gi))) begin
                  wr_en   = 1'b1;
                  wr_data = in_lane[j];
               end
            end
         end

         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem_q[gi] <= wr_data;
            end
         end
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_out
         logic [PTR_W-1:0] rd_idx;
         assign rd_idx = head_q + PTR_W'(gi);
         assign out_entry_flat[(3-gi)*ENTRY_W +: ENTRY_W] = mem_q[rd_idx];
         assign out_valid[3-gi] = (occ_q > CNT_W'(gi));
      end
   endgenerate

   assign num_free  = free_cnt;
   assign occupancy = occ_q;

`ifdef IBUF_ERR_CHECK_EN
   logic err_q, err_d;

   // Attempts are judged on clamped requests; a flush edge never raises the flag.
   always_comb begin
      err_d = err_q;
      if (!flush && ((in_clamp > free_cnt) || (deq_clamp > avail_cnt))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_buffer.sv
// Directed table-driven bench for instruction_buffer (DEPTH 8, ENTRY_W 41).
module tb_instruction_buffer;

   localparam int EW = 41;
`ifdef IBUF_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic [2:0]    in_count;
   logic [4*EW-1:0] in_entry_flat;
   logic [2:0]    num_free;
   logic [4*EW-1:0] out_entry_flat;
   logic [3:0]    out_valid;
   logic [2:0]    deq_count;
   logic [3:0]    occupancy;
   logic          err;

   int checks   = 0;
   int failures = 0;

   instruction_buffer #(.DEPTH(8), .ENTRY_W(EW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .in_count       (in_count),
      .in_entry_flat  (in_entry_flat),
      .num_free       (num_free),
      .out_entry_flat (out_entry_flat),
      .out_valid      (out_valid),
      .deq_count      (deq_count),
      .occupancy      (occupancy),
      .err            (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic [2:0]  inc;
      logic [2:0]  dq;
      int          tag;
      int          occ;
      int          fr;
      logic [3:0]  vld;
      logic [31:0] tags;
      logic        e;
   } vec_t;

   vec_t vecs [15];

   function automatic logic [EW-1:0] mk_entry(input int t);
      logic [7:0] b;
      b = 8'(t);
      return {1'b1, b, b, b, b, b};
   endfunction

   function automatic vec_t mkv(input logic fl, input int inc, input int dq, input int tag,
                                input int occ, input int fr, input logic [3:0] vld,
                                input logic [31:0] tags, input logic e);
      vec_t v;
      v.fl = fl; v.inc = 3'(inc); v.dq = 3'(dq); v.tag = tag;
      v.occ = occ; v.fr = fr; v.vld = vld; v.tags = tags; v.e = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic [2:0] inc, input logic [2:0] dq, input int tag);
      flush     = fl;
      in_count  = inc;
      deq_count = dq;
      for (int j = 0; j < 4; j++) begin
         in_entry_flat[(3-j)*EW +: EW] = mk_entry(tag + j);
      end
   endtask

   task automatic check_state(input string nm, input int occ, input int fr,
                              input logic [3:0] vld, input logic [31:0] tags, input logic e);
      check({nm, "_occ"},   64'(occupancy), 64'(occ));
      check({nm, "_free"},  64'(num_free),  64'(fr));
      check({nm, "_valid"}, 64'(out_valid), 64'(vld));
      check({nm, "_err"},   64'(err),       64'(e & ERR_EN));
      for (int i = 0; i < 4; i++) begin
         if (vld[3-i]) begin
            check($sformatf("%s_lane%0d", nm, i),
                  64'(out_entry_flat[(3-i)*EW +: EW]),
                  64'(mk_entry(int'(tags[31-8*i -: 8]))));
         end
      end
   endtask

   initial begin
      vecs[0]  = mkv(0, 4, 0,  1, 4, 4, 4'hF, 32'h01020304, 0);
      vecs[1]  = mkv(0, 4, 0,  5, 8, 0, 4'hF, 32'h01020304, 0);
      vecs[2]  = mkv(0, 2, 0,  9, 8, 0, 4'hF, 32'h01020304, 1);
      vecs[3]  = mkv(0, 0, 4,  0, 4, 4, 4'hF, 32'h05060708, 1);
      vecs[4]  = mkv(0, 0, 1,  0, 3, 4, 4'hE, 32'h06070800, 1);
      vecs[5]  = mkv(0, 3, 0, 11, 6, 2, 4'hF, 32'h0607080B, 1);
      vecs[6]  = mkv(0, 2, 3, 14, 5, 3, 4'hF, 32'h0B0C0D0E, 1);
      vecs[7]  = mkv(0, 0, 2,  0, 3, 4, 4'hE, 32'h0D0E0F00, 1);
      vecs[8]  = mkv(0, 0, 4,  0, 0, 4, 4'h0, 32'h00000000, 1);
      vecs[9]  = mkv(0, 4, 0, 16, 4, 4, 4'hF, 32'h10111213, 1);
      vecs[10] = mkv(0, 1, 0, 20, 5, 3, 4'hF, 32'h10111213, 1);
      vecs[11] = mkv(1, 4, 2, 21, 0, 4, 4'h0, 32'h00000000, 1);
      vecs[12] = mkv(0, 7, 0, 22, 4, 4, 4'hF, 32'h16171819, 1);
      vecs[13] = mkv(0, 4, 7, 26, 4, 4, 4'hF, 32'h1A1B1C1D, 1);
      vecs[14] = mkv(0, 3, 0, 30, 7, 1, 4'hF, 32'h1A1B1C1D, 1);

      rst_n = 1'b0;
      drive(0, 0, 0, 0);
      #2;
      check_state("reset", 0, 4, 4'h0, 32'h0, 0);
      $display("txn reset occ=%0d free=%0d valid=%b err=%b", occupancy, num_free, out_valid, err);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         drive(vecs[k].fl, vecs[k].inc, vecs[k].dq, vecs[k].tag);
         @(posedge clk);
         #1;
         check_state($sformatf("vec%0d", k), vecs[k].occ, vecs[k].fr,
                     vecs[k].vld, vecs[k].tags, vecs[k].e);
         $display("txn vec%0d fl=%b in=%0d deq=%0d -> occ=%0d free=%0d valid=%b err=%b",
                  k, vecs[k].fl, vecs[k].inc, vecs[k].dq, occupancy, num_free, out_valid, err);
      end

      // Asynchronous reset mid-cycle with occupancy 7: state clears without a clock edge.
      @(negedge clk);
      drive(0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_state("async_rst", 0, 4, 4'h0, 32'h0, 0);
      $display("txn async_rst occ=%0d free=%0d valid=%b err=%b", occupancy, num_free, out_valid, err);

      // First enqueue at the first rising edge after deassertion.
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1, 0, 40);
      @(posedge clk);
      #1;
      check_state("post_rst_enq", 1, 4, 4'h8, 32'h28000000, 0);
      $display("txn post_rst_enq occ=%0d free=%0d valid=%b err=%b", occupancy, num_free, out_valid, err);

      // Underflow attempt alone raises err when checking is built in.
      @(negedge clk);
      drive(0, 0, 2, 0);
      @(posedge clk);
      #1;
      check_state("underflow", 0, 4, 4'h0, 32'h0, 1);
      $display("txn underflow occ=%0d free=%0d valid=%b err=%b", occupancy, num_free, out_valid, err);

      @(negedge clk);
      drive(0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
